rf_write_arbiter: RTL and testbench

Shares the single register-file write port between two writeback requesters: A is ALU writeback and B is load writeback. Each requester has a one-entry holding slot, and pending writes are granted round-robin. The granted address is decoded into the one-hot per-register enable vector that drives the 32 register32 instances, along with the shared write data. Writes to register 0 are consumed but never enabled.

---
 rtl/rf_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_rf_write_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: two one-entry holding slots (ALU and load writeback)
// drained round-robin into a registered one-hot enable, address and data for the register array.
module rf_write_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_data,
  output logic [NREG-1:0]   wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic [15:0]       stall_cnt
);

  logic              r_a_full;
  logic [ADDR_W-1:0] r_a_addr;
  logic [WIDTH-1:0]  r_a_data;
  logic              r_b_full;
  logic [ADDR_W-1:0] r_b_addr;
  logic [WIDTH-1:0]  r_b_data;
  logic              r_last_b;

  logic [NREG-1:0]   r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WIDTH-1:0]  r_wr_data;
  logic [15:0]       r_stall_cnt;

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_grant;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [WIDTH-1:0]  w_gnt_data;
  logic [NREG-1:0]   w_dec;
  logic              w_a_xfer;
  logic              w_b_xfer;
  logic              w_stall;

  // Round-robin only matters on a tie; the requester not served last wins.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    unique case ({r_a_full, r_b_full})
      2'b10: w_grant_a = 1'b1;
      2'b01: w_grant_b = 1'b1;
      2'b11: begin
        if (r_last_b) begin
          w_grant_a = 1'b1;
        end else begin
          w_grant_b = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_grant = w_grant_a | w_grant_b;

  // Register 0 is never enabled, so bit 0 of the decode is left clear.
  always_comb begin
    w_gnt_addr = w_grant_b ? r_b_addr : r_a_addr;
    w_gnt_data = w_grant_b ? r_b_data : r_a_data;
    w_dec      = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (w_gnt_addr == ADDR_W'(i)) begin
        w_dec[i] = 1'b1;
      end
    end
  end

  // A slot being drained this cycle can take a new entry on the same edge.
  assign a_ready  = !reset && (!r_a_full || w_grant_a);
  assign b_ready  = !reset && (!r_b_full || w_grant_b);
  assign w_a_xfer = a_valid && a_ready;
  assign w_b_xfer = b_valid && b_ready;
  assign w_stall  = (a_valid && !a_ready) || (b_valid && !b_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_full <= 1'b0;
      r_a_addr <= '0;
      r_a_data <= '0;
    end else if (w_a_xfer) begin
      r_a_full <= 1'b1;
      r_a_addr <= a_addr;
      r_a_data <= a_data;
    end else if (w_grant_a) begin
      r_a_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_b_full <= 1'b0;
      r_b_addr <= '0;
      r_b_data <= '0;
    end else if (w_b_xfer) begin
      r_b_full <= 1'b1;
      r_b_addr <= b_addr;
      r_b_data <= b_data;
    end else if (w_grant_b) begin
      r_b_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_b <= 1'b1;
    end else if (w_grant) begin
      r_last_b <= w_grant_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_grant) begin
      r_wr_en   <= w_dec;
      r_wr_addr <= w_gnt_addr;
      r_wr_data <= w_gnt_data;
    end else begin
      r_wr_en   <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_a_full || r_b_full;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: hand-computed vector table, async-reset sequence, and
// streaming/random traffic against a slot-level reference model with a register scoreboard.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, wr_addr;
  logic [31:0] a_data, b_data, wr_data, wr_en;
  logic        busy;
  logic [15:0] stall_cnt;

  rf_write_arbiter #(
    .WIDTH (32),
    .ADDR_W(5),
    .NREG  (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic [31:0] e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_ar;
    logic        e_br;
    logic        e_busy;
    logic [15:0] e_stall;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic av, input logic [4:0] aa,
                              input logic [31:0] ad, input logic bv, input logic [4:0] ba,
                              input logic [31:0] bd, input logic [31:0] en, input logic [4:0] wa,
                              input logic [31:0] wd, input logic ar, input logic br,
                              input logic bsy, input logic [15:0] st);
    vec_t v;
    v.rst = rst; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.e_en = en; v.e_addr = wa; v.e_data = wd; v.e_ar = ar; v.e_br = br; v.e_busy = bsy;
    v.e_stall = st;
    return v;
  endfunction

  vec_t tbl[23];

  // Reference model: slot contents, round-robin owner, registered write outputs, shadow RF.
  bit          m_full[2];
  logic [4:0]  m_addr[2];
  logic [31:0] m_data[2];
  int          m_last;
  logic [31:0] m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  int          m_stall;
  logic [31:0] m_rf[32];
  logic [31:0] d_rf[32];
  int          exp_pulses, got_pulses;

  bit          r_v[2];
  logic [4:0]  r_a[2];
  logic [31:0] r_d[2];
  int          rem[2];

  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      m_full[x] = 0; m_addr[x] = '0; m_data[x] = '0; r_v[x] = 0;
    end
    m_last = 1;
    m_wr_en = '0; m_wr_addr = '0; m_wr_data = '0; m_stall = 0;
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = '0; d_rf[i] = '0;
    end
    exp_pulses = 0; got_pulses = 0;
  endtask

  function automatic int m_grant();
    if (m_full[0] && m_full[1]) return 1 - m_last;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  task automatic idle_inputs();
    a_valid = 0; a_addr = '0; a_data = '0;
    b_valid = 0; b_addr = '0; b_data = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_model(input string tag, input bit stream, input int n, input int max_cyc);
    int  g;
    bit  rdy[2];
    bit  done;
    int  src_exp;
    src_exp = 0;
    done = 0;
    rem[0] = n; rem[1] = n;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      for (int x = 0; x < 2; x++) begin
        if (!r_v[x] && rem[x] > 0 && (stream || $urandom_range(0, 2) != 0)) begin
          r_v[x] = 1;
          r_a[x] = stream ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 31));
          r_d[x] = $urandom;
          if (stream) r_d[x][31] = (x == 1);
          rem[x]--;
        end
      end
      @(posedge clk); #1;
      a_valid = r_v[0]; a_addr = r_a[0]; a_data = r_d[0];
      b_valid = r_v[1]; b_addr = r_a[1]; b_data = r_d[1];
      g = m_grant();
      for (int x = 0; x < 2; x++) rdy[x] = !m_full[x] || (g == x);
      @(negedge clk);
      chk({tag, ".a_ready"}, 64'(a_ready), 64'(rdy[0]));
      chk({tag, ".b_ready"}, 64'(b_ready), 64'(rdy[1]));
      chk({tag, ".wr_en"}, 64'(wr_en), 64'(m_wr_en));
      chk({tag, ".wr_addr"}, 64'(wr_addr), 64'(m_wr_addr));
      chk({tag, ".wr_data"}, 64'(wr_data), 64'(m_wr_data));
      chk({tag, ".busy"}, 64'(busy), 64'(m_full[0] || m_full[1]));
      chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
      for (int i = 0; i < 32; i++) begin
        if (wr_en[i]) begin
          d_rf[i] = wr_data;
          got_pulses++;
        end
      end
      if (stream && wr_en != 0) begin
        chk({tag, ".alternation"}, 64'(wr_data[31]), 64'(src_exp));
        src_exp = 1 - src_exp;
      end
      if (m_wr_en != 0) begin
        m_rf[m_wr_addr] = m_wr_data;
        exp_pulses++;
      end
      // Advance the model across the coming edge.
      if (((r_v[0] && !rdy[0]) || (r_v[1] && !rdy[1])) && m_stall < 65535) m_stall++;
      if (g >= 0) begin
        m_wr_en   = (m_addr[g] == 0) ? 32'h0 : (32'h1 << m_addr[g]);
        m_wr_addr = m_addr[g];
        m_wr_data = m_data[g];
        m_last    = g;
        m_full[g] = 0;
      end else begin
        m_wr_en = '0;
      end
      for (int x = 0; x < 2; x++) begin
        if (r_v[x] && rdy[x]) begin
          m_full[x] = 1; m_addr[x] = r_a[x]; m_data[x] = r_d[x]; r_v[x] = 0;
        end
      end
      if (rem[0] == 0 && rem[1] == 0 && !r_v[0] && !r_v[1] && !m_full[0] && !m_full[1]
          && m_wr_en == 0) begin
        done = 1;
        idle_inputs();
      end
    end
    idle_inputs();
    chk({tag, ".completed"}, 64'(done), 64'(1));
    chk({tag, ".pulses"}, 64'(got_pulses), 64'(exp_pulses));
    if (stream) chk({tag, ".pulse_total"}, 64'(got_pulses), 64'(2 * n));
    for (int i = 0; i < 32; i++) chk($sformatf("%s.rf%0d", tag, i), 64'(d_rf[i]), 64'(m_rf[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             rst av aa  ad            bv ba  bd            en            wa  wd            ar br bsy st
    tbl[0]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        32'h0,        0,  32'h0,        1, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        0,  32'h0,        1, 1, 1, 0);
    tbl[2]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h20,       5,  32'hDEADBEEF, 1, 1, 0, 0);
    tbl[3]  = mk(1, 0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        0,  32'h0,        0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 3,  32'h11111111, 1, 4,  32'h22222222, 32'h0,        0,  32'h0,        1, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        0,  32'h0,        1, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h08,       3,  32'h11111111, 1, 1, 1, 0);
    tbl[7]  = mk(0, 0, 0,  32'h0,        1, 0,  32'hFFFFFFFF, 32'h10,       4,  32'h22222222, 1, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        4,  32'h22222222, 1, 1, 1, 0);
    tbl[9]  = mk(0, 1, 9,  32'hA9A9A9A9, 1, 10, 32'hB0B0B0B0, 32'h0,        0,  32'hFFFFFFFF, 1, 1, 0, 0);
    tbl[10] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        0,  32'hFFFFFFFF, 1, 0, 1, 0);
    tbl[11] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h200,      9,  32'hA9A9A9A9, 1, 1, 1, 0);
    tbl[12] = mk(0, 1, 7,  32'h77770001, 1, 7,  32'h77770002, 32'h400,      10, 32'hB0B0B0B0, 1, 1, 0, 0);
    tbl[13] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        10, 32'hB0B0B0B0, 1, 0, 1, 0);
    tbl[14] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h80,       7,  32'h77770001, 1, 1, 1, 0);
    tbl[15] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h80,       7,  32'h77770002, 1, 1, 0, 0);
    tbl[16] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h0,        7,  32'h77770002, 1, 1, 0, 0);
    tbl[17] = mk(0, 1, 1,  32'h1,        1, 2,  32'h2,        32'h0,        7,  32'h77770002, 1, 1, 0, 0);
    tbl[18] = mk(0, 1, 11, 32'hB,        1, 12, 32'hC,        32'h0,        7,  32'h77770002, 1, 0, 1, 0);
    tbl[19] = mk(0, 0, 0,  32'h0,        1, 12, 32'hC,        32'h2,        1,  32'h1,        0, 1, 1, 1);
    tbl[20] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h4,        2,  32'h2,        1, 0, 1, 1);
    tbl[21] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h800,      11, 32'hB,        1, 1, 1, 1);
    tbl[22] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        32'h1000,     12, 32'hC,        1, 1, 0, 1);

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      reset   = tbl[i].rst;
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      @(negedge clk);
      chk($sformatf("v%0d.wr_en", i), 64'(wr_en), 64'(tbl[i].e_en));
      chk($sformatf("v%0d.wr_addr", i), 64'(wr_addr), 64'(tbl[i].e_addr));
      chk($sformatf("v%0d.wr_data", i), 64'(wr_data), 64'(tbl[i].e_data));
      chk($sformatf("v%0d.a_ready", i), 64'(a_ready), 64'(tbl[i].e_ar));
      chk($sformatf("v%0d.b_ready", i), 64'(b_ready), 64'(tbl[i].e_br));
      chk($sformatf("v%0d.busy", i), 64'(busy), 64'(tbl[i].e_busy));
      chk($sformatf("v%0d.stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].e_stall));
    end

    // Async reset while both slots are full and a write is on the port.
    do_reset();
    @(posedge clk); #1;
    a_valid = 1; a_addr = 13; a_data = 32'hD;
    b_valid = 1; b_addr = 14; b_data = 32'hE;
    @(posedge clk); #1;
    a_addr = 15; a_data = 32'hF;
    b_addr = 16; b_data = 32'h10;
    @(posedge clk); #1;
    idle_inputs();
    chk("ar.pre_wr_en", 64'(wr_en), 64'(32'h1 << 13));
    chk("ar.pre_busy", 64'(busy), 64'(1));
    chk("ar.pre_stall", 64'(stall_cnt), 64'(1));
    reset = 1'b1;
    #1;
    chk("ar.wr_en", 64'(wr_en), 64'(0));
    chk("ar.wr_addr", 64'(wr_addr), 64'(0));
    chk("ar.busy", 64'(busy), 64'(0));
    chk("ar.stall", 64'(stall_cnt), 64'(0));
    chk("ar.a_ready", 64'(a_ready), 64'(0));
    chk("ar.b_ready", 64'(b_ready), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("ar.post%0d.wr_en", c), 64'(wr_en), 64'(0));
      chk($sformatf("ar.post%0d.busy", c), 64'(busy), 64'(0));
      chk($sformatf("ar.post%0d.a_ready", c), 64'(a_ready), 64'(1));
      chk($sformatf("ar.post%0d.b_ready", c), 64'(b_ready), 64'(1));
    end

    do_reset();
    run_model("stream", 1'b1, 8, 60);
    do_reset();
    run_model("random", 1'b0, 100, 600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
